// File: rtl/adc_packetizer_pkg.sv
// rtl/adc_packetizer_pkg.sv - shared types and constants for the ADC packetizer
package adc_packetizer_pkg;

    localparam int SAMPLE_W_DEFAULT = 16;
    localparam int AXIS_W_DEFAULT   = 32;
    localparam int BYTES_PER_BEAT   = 4;
    localparam int BEAT_SHIFT       = $clog2(BYTES_PER_BEAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/adc_packetizer_if.sv
// rtl/adc_packetizer_if.sv - output beat stream towards the DMA
interface adc_packetizer_if
    import adc_packetizer_pkg::*;
#(
    parameter int AXIS_W = AXIS_W_DEFAULT
);
    logic [AXIS_W-1:0]   tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic [AXIS_W/8-1:0] tkeep;

    modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/adc_packetizer_beat_fifo.sv
// rtl/adc_packetizer_beat_fifo.sv - first-word-fall-through beat FIFO (data + last)
module beat_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Head is forced to zero when empty so stale entries never show after reset.
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Storage array; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/adc_packetizer.sv
// rtl/adc_packetizer.sv - packs ADC sample pairs into fixed-length stream packets
module adc_packetizer
    import adc_packetizer_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
    parameter int AXIS_W     = AXIS_W_DEFAULT,
    parameter int SIZE_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                start,
    input  logic [SIZE_W-1:0]   packet_size,
    adc_packetizer_if.master    m_axis,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                size_err
);
    localparam int CNT_W = SIZE_W - BEAT_SHIFT;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_beats;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic                r_half;
    logic [SAMPLE_W-1:0] r_low;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;
    logic                r_size_err;

    logic [CNT_W-1:0]      w_start_beats;
    logic [BEAT_SHIFT-1:0] w_unused_size_lsb;
    logic                  w_pop;
    logic                  w_beat_fire;
    logic                  w_push;
    logic                  w_last;
    logic                  w_full;
    logic                  w_empty;
    logic [AXIS_W:0]       w_fifo_din;
    logic [AXIS_W:0]       w_fifo_dout;

    // Byte count is truncated to whole beats; the remainder bytes are dropped.
    assign w_start_beats     = packet_size[SIZE_W-1:BEAT_SHIFT];
    assign w_unused_size_lsb = packet_size[BEAT_SHIFT-1:0];

    assign w_pop       = m_axis.tvalid && m_axis.tready;
    assign w_beat_fire = (r_state == FILL) && adc_valid && r_half;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push      = w_beat_fire && (!w_full || w_pop);
    assign w_last      = (r_beat_cnt == r_beats - CNT_ONE);
    assign w_fifo_din  = {w_last, adc_data, r_low};

    beat_fifo #(
        .WIDTH (AXIS_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_axis.tdata  = w_fifo_dout[AXIS_W-1:0];
    assign m_axis.tlast  = w_fifo_dout[AXIS_W];
    assign m_axis.tvalid = !w_empty;
    assign m_axis.tkeep  = '1;

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign size_err = r_size_err;

    // Packet control: accept start, pair samples into beats, wait for last handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_beats    <= '0;
            r_beat_cnt <= '0;
            r_half     <= 1'b0;
            r_low      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_size_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_start_beats == '0) begin
                            r_size_err <= 1'b1;
                        end else begin
                            r_beats    <= w_start_beats;
                            r_beat_cnt <= '0;
                            r_half     <= 1'b0;
                            r_overflow <= 1'b0;
                            r_size_err <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (adc_valid) begin
                        if (!r_half) begin
                            r_low  <= adc_data;
                            r_half <= 1'b1;
                        end else begin
                            r_half <= 1'b0;
                            // A dropped beat keeps the count, so packet length is preserved.
                            if (w_push) begin
                                if (w_last) r_state <= DRAIN;
                                else        r_beat_cnt <= r_beat_cnt + CNT_ONE;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && m_axis.tlast) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_packetizer.sv
// tb/tb_adc_packetizer.sv - self-checking bench for adc_packetizer
module tb_adc_packetizer;
    import adc_packetizer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        start = 1'b0;
    logic [31:0] packet_size = '0;
    logic        busy, done, overflow, size_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int rdy_release = 0;
    int done_cnt = 0;

    logic [32:0] got[$];
    logic [15:0] sq[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;

    adc_packetizer_if u_if ();

    adc_packetizer dut (
        .clk         (clk),
        .resetn      (resetn),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .start       (start),
        .packet_size (packet_size),
        .m_axis      (u_if),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .size_err    (size_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (prev_stall) begin
                check("stall_valid", 64'(u_if.tvalid), 64'd1);
                check("stall_beat", 64'({u_if.tlast, u_if.tdata}), 64'(prev_beat));
            end
            if (u_if.tvalid && u_if.tready) got.push_back({u_if.tlast, u_if.tdata});
            if (done) done_cnt++;
            prev_stall = u_if.tvalid && !u_if.tready;
            prev_beat  = {u_if.tlast, u_if.tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic drive_cycle(input logic v, input logic [15:0] d);
        adc_valid = v;
        adc_data  = d;
        case (rdy_mode)
            0:       u_if.tready = 1'b1;
            1:       u_if.tready = (cyc % 4 == 0);
            default: u_if.tready = (cyc >= rdy_release);
        endcase
        @(posedge clk);
        #1;
        cyc++;
        adc_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (done_cnt == 0 && k < bound) begin
            drive_cycle(1'b0, 16'h0);
            k++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (3) drive_cycle(1'b0, 16'h0);
    endtask

    // Reference: beat k is samples 2k and 2k+1 taken after start, last flag on final beat.
    task automatic run_packet(input string tag, input int size, input int gap, input int mode,
                              input int busy_at, input logic exp_ovf);
        int beats = size >> 2;
        int n = 0;
        logic [15:0] d;
        logic [32:0] e;
        got.delete();
        sq.delete();
        done_cnt = 0;
        rdy_mode = mode;
        start = 1'b1;
        packet_size = 32'(size);
        drive_cycle(1'b0, 16'h0);
        check({tag, "_busy_set"}, 64'(busy), 64'd1);
        while (n < 2 * beats) begin
            for (int g = 1; g < gap; g++) drive_cycle(1'b0, 16'h0);
            d = 16'($urandom);
            if (n == busy_at) begin
                start = 1'b1;
                packet_size = 32'd8;
            end
            drive_cycle(1'b1, d);
            sq.push_back(d);
            n++;
        end
        wait_done(tag, 40 * beats + 100);
        check({tag, "_beat_count"}, 64'(got.size()), 64'(beats));
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_clear"}, 64'(busy), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        for (int k = 0; k < beats && k < got.size(); k++) begin
            e = {(k == beats - 1), sq[2*k+1], sq[2*k]};
            check({tag, "_beat"}, 64'(got[k]), 64'(e));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 64'(u_if.tvalid), 64'd0);
        check({tag, "_tlast"}, 64'(u_if.tlast), 64'd0);
        check({tag, "_tdata"}, 64'(u_if.tdata), 64'd0);
        check({tag, "_tkeep"}, 64'(u_if.tkeep), 64'hf);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_size_err"}, 64'(size_err), 64'd0);
    endtask

    initial begin
        int k;
        int n;
        logic [15:0] m_prev;
        u_if.tready = 1'b1;

        // Reset state
        repeat (3) drive_cycle(1'b0, 16'h0);
        check_reset_outputs("reset");
        resetn = 1'b1;
        drive_cycle(1'b0, 16'h0);

        // Samples while idle are discarded
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 16'($urandom));
        check("idle_no_beats", 64'(got.size()), 64'd0);

        // Nominal: long packet, one sample every 4 clocks, always ready
        run_packet("nominal", 2048, 4, 0, -1, 1'b0);

        // Backpressure: sample every 8 clocks, ready 1 of 4 clocks
        run_packet("backpressure", 64, 8, 1, -1, 1'b0);

        // Random sizes (with ignored low bits) and gaps under backpressure
        for (int r = 0; r < 3; r++)
            run_packet("random", 4 * $urandom_range(1, 20) + $urandom_range(0, 3),
                       $urandom_range(3, 6), 1, -1, 1'b0);

        // Overflow: sample every clock, ready held low for 20 clocks
        got.delete();
        done_cnt = 0;
        rdy_mode = 2;
        rdy_release = cyc + 20;
        start = 1'b1;
        packet_size = 32'd64;
        drive_cycle(1'b0, 16'h0);
        n = 0;
        k = 0;
        while (done_cnt == 0 && k < 400) begin
            drive_cycle(1'b1, 16'(n));
            n++;
            k++;
        end
        check("ovf_done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (3) drive_cycle(1'b0, 16'h0);
        check("ovf_beat_count", 64'(got.size()), 64'd16);
        check("ovf_done_once", 64'(done_cnt), 64'd1);
        check("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check("ovf_first_beats", 64'(got[i]), 64'({1'b0, 16'(2*i+1), 16'(2*i)}));
        m_prev = 16'h0;
        for (int i = 0; i < got.size(); i++) begin
            check("ovf_pair", 64'(got[i][31:16]), 64'(got[i][15:0] + 16'd1));
            check("ovf_even", 64'(got[i][0]), 64'd0);
            if (i > 0) check("ovf_order", 64'(got[i][15:0] > m_prev), 64'd1);
            check("ovf_last", 64'(got[i][32]), 64'(i == 15));
            m_prev = got[i][15:0];
        end

        // Size edge: 2 bytes is rejected
        rdy_mode = 0;
        got.delete();
        start = 1'b1;
        packet_size = 32'd2;
        drive_cycle(1'b0, 16'h0);
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 16'($urandom));
        check("size2_err", 64'(size_err), 64'd1);
        check("size2_busy", 64'(busy), 64'd0);
        check("size2_no_beats", 64'(got.size()), 64'd0);

        // Size edge: 6 bytes is one beat, clears size_err
        run_packet("size6", 6, 2, 0, -1, 1'b0);
        check("size6_err_clear", 64'(size_err), 64'd0);

        // Start while busy is ignored
        run_packet("busy_start", 64, 2, 0, 5, 1'b0);

        // Reset mid-packet after 5 beats
        got.delete();
        rdy_mode = 0;
        start = 1'b1;
        packet_size = 32'd64;
        drive_cycle(1'b0, 16'h0);
        k = 0;
        while (got.size() < 5 && k < 200) begin
            drive_cycle(k[0], 16'($urandom));
            k++;
        end
        check("rst_mid_progress", 64'(got.size() >= 5), 64'd1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        drive_cycle(1'b1, 16'h1234);
        check_reset_outputs("rst_mid_hold");
        resetn = 1'b1;
        drive_cycle(1'b0, 16'h0);
        run_packet("after_reset", 64, 2, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_packetizer.md
Name: adc_packetizer

Overview:
- Sits between the ADC capture front end and the AXI DMA S2MM stream input of the digitizer.
- Takes 16-bit ADC samples qualified by a strobe and packs two samples per 32-bit AXI-Stream beat.
- Emits exactly one packet of packet_size bytes per start command, with TLAST on the final beat.
- Buffers beats in a small FIFO against DMA backpressure and reports busy/done/overflow to the control register block (start at 0x6000_0000, size at 0x6000_0008).

Parameters:
- SAMPLE_W, 16, ADC sample width.
- AXIS_W, 32, stream data width; must equal 2*SAMPLE_W.
- SIZE_W, 32, width of packet_size.
- FIFO_DEPTH, 4, beat FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  single clock; samples are already synchronised into this domain upstream.
- resetn  in  1  asynchronous, active-low reset.
- adc_data  in  SAMPLE_W  sample, valid when adc_valid=1.
- adc_valid  in  1  one-cycle sample strobe.
- start  in  1  one-cycle pulse from register block.
- packet_size  in  SIZE_W  packet length in bytes; sampled on start.
- m_axis_tdata  out  AXIS_W  beat data.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  DMA ready.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tkeep  out  AXIS_W/8  constant all ones.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse on final beat acceptance.
- overflow  out  1  sticky: a beat was dropped in the current or last packet.
- size_err  out  1  sticky: last start was rejected because packet_size < 4.

Behaviour:
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, overflow=0, size_err=0; FIFO empty; state IDLE. Reset mid-packet aborts the packet and emits no partial TLAST.
- beats = packet_size >> 2. Bits [1:0] are ignored, so 6 bytes gives 1 beat.
- States:
  - IDLE: samples are discarded.
    - start with beats=0 sets size_err and stays IDLE.
    - start with beats>=1 latches beats, clears beat_cnt, the half flag, overflow and size_err, sets busy, and goes to FILL.
  - FILL:
    - Each adc_valid with half=0 stores the sample into the low register and sets half=1.
    - Each adc_valid with half=1 forms beat {adc_data, low}, so the first sample goes in [15:0].
    - The beat is written to the FIFO with tlast=(beat_cnt==beats-1).
    - When the FIFO is full and not popping that cycle, the beat is dropped, overflow is set, and beat_cnt does not advance. Packet length is preserved; data is discontinuous.
    - After the write of the last beat, go to DRAIN. Further samples are discarded.
  - DRAIN: wait for the handshake tvalid & tready & tlast. In the cycle after that edge: done=1 (one cycle), busy=0, state IDLE.
- start while busy is ignored; no flags change.
- FIFO is first-word-fall-through. A beat written at edge N appears on tdata/tvalid in the cycle after N. Simultaneous push and pop while full is allowed and is not an overflow.
- tdata/tlast are held stable while tvalid=1 and tready=0 (AXI-Stream rule).
- beat_cnt is SIZE_W-2 bits wide. Terminal comparison is equality, so there is no wrap inside a packet. The maximum packet is (2^SIZE_W - 4) bytes.

Decomposition:
- digitizer_pkg:
  - state enum {IDLE, FILL, DRAIN};
  - SAMPLE_W/AXIS_W defaults;
  - BYTES_PER_BEAT=4 constant.
- Sub-module beat_fifo: sync FWFT FIFO, width AXIS_W+1 (data+last), depth FIFO_DEPTH, with full/empty flags. It is instantiated once. All control logic and the packer stay in adc_packetizer.

Test Plan:
- Nominal:
  - Stimulus: packet_size=65536, counting samples one every 4 clks, tready=1.
  - Response: 16384 beats; beat k = {2k+1, 2k} (16-bit halves); tlast only on beat 16383; one done pulse; busy low afterwards; overflow=0.
- Backpressure:
  - Stimulus: packet_size=64, samples every 8 clks, tready toggling 1 clk on / 3 clks off.
  - Response: 16 beats in order; tdata stable while stalled; overflow=0.
- Overflow:
  - Stimulus: packet_size=64, samples every clk, tready=0 for 20 clks then 1.
  - Response: first 4 beats are {1,0}..{7,6}; overflow=1; still exactly 16 beats with tlast on the 16th; done pulses.
- Size edge cases:
  - packet_size=2: size_err=1, busy stays 0, no beats.
  - packet_size=6: 1 beat with tlast=1.
- Start while busy:
  - Stimulus: second start mid-packet with size=8.
  - Response: ignored; original length is kept.
- Reset:
  - Stimulus: resetn low after 5 beats of a 64-byte packet.
  - Response: all outputs return to reset values; FIFO empty; the next start produces a full clean packet starting at the next sample.
